alu_iter: RTL and testbench



---
 rtl/alu_iter.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter
//  Purpose  : Registered ALU with iterative multiply/divide and HI/LO
//             registers. Single-cycle ops complete in one clock; MULT/DIV
//             run a shift-add / restoring-divide sequence, one bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam logic [OPW-1:0] c_OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] c_OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] c_OP_SLL   = OPW'(2);
    localparam logic [OPW-1:0] c_OP_SRL   = OPW'(3);
    localparam logic [OPW-1:0] c_OP_SRA   = OPW'(4);
    localparam logic [OPW-1:0] c_OP_AND   = OPW'(5);
    localparam logic [OPW-1:0] c_OP_OR    = OPW'(6);
    localparam logic [OPW-1:0] c_OP_XOR   = OPW'(7);
    localparam logic [OPW-1:0] c_OP_NOR   = OPW'(8);
    localparam logic [OPW-1:0] c_OP_SLT   = OPW'(9);
    localparam logic [OPW-1:0] c_OP_SLTU  = OPW'(10);
    localparam logic [OPW-1:0] c_OP_LUI   = OPW'(11);
    localparam logic [OPW-1:0] c_OP_MULT  = OPW'(16);
    localparam logic [OPW-1:0] c_OP_MULTU = OPW'(17);
    localparam logic [OPW-1:0] c_OP_DIV   = OPW'(18);
    localparam logic [OPW-1:0] c_OP_DIVU  = OPW'(19);
    localparam logic [OPW-1:0] c_OP_MFHI  = OPW'(20);
    localparam logic [OPW-1:0] c_OP_MFLO  = OPW'(21);
    localparam logic [OPW-1:0] c_OP_MTHI  = OPW'(22);
    localparam logic [OPW-1:0] c_OP_MTLO  = OPW'(23);

    localparam logic [SHW:0]   c_CNT_INIT = (SHW+1)'(WIDTH);
    localparam int             c_HW       = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [2*WIDTH-1:0]   r_acc;      // {hi-part, lo-part} working register
    logic [WIDTH-1:0]     r_md;       // multiplicand / divisor magnitude
    logic [SHW:0]         r_cnt;
    logic                 r_is_div;
    logic                 r_neg;      // product/quotient must be negated
    logic                 r_sa;       // remainder must be negated (sign of a)
    logic                 r_dz;       // divide-by-zero shortcut in progress

    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_div0;

    logic                 w_iter;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_alu;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_step;

    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fin_hi;
    logic [WIDTH-1:0]     w_fin_lo;

    assign busy   = (r_state == S_CALC) || (r_state == S_SIGN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign zero   = r_zero;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign div0   = r_div0;

    // Decode the incoming op and form operand magnitudes for signed mul/div
    always_comb begin
        w_iter     = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                     (op == c_OP_DIV)  || (op == c_OP_DIVU);
        w_is_div   = (op == c_OP_DIV)  || (op == c_OP_DIVU);
        w_signed   = (op == c_OP_MULT) || (op == c_OP_DIV);
        w_div_zero = w_is_div && (b == '0);
        w_a_mag    = (w_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag    = (w_signed && b[WIDTH-1]) ? -b : b;
    end

    // Single-cycle ALU result from live inputs
    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_ADD:  w_alu = a + b;
            c_OP_SUB:  w_alu = a - b;
            c_OP_SLL:  w_alu = b << a[SHW-1:0];
            c_OP_SRL:  w_alu = b >> a[SHW-1:0];
            c_OP_SRA:  w_alu = $signed(b) >>> a[SHW-1:0];
            c_OP_AND:  w_alu = a & b;
            c_OP_OR:   w_alu = a | b;
            c_OP_XOR:  w_alu = a ^ b;
            c_OP_NOR:  w_alu = ~(a | b);
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_LUI:  w_alu = {b[c_HW-1:0], {c_HW{1'b0}}};
            c_OP_MFHI: w_alu = r_hi;
            c_OP_MFLO: w_alu = r_lo;
            c_OP_MTHI: w_alu = a;
            c_OP_MTLO: w_alu = a;
            default:   w_alu = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide, plus sign fix-up
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_md} : '0);
        w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff = w_rem_sh - {1'b0, r_md};
        // A borrow means the shifted remainder was smaller than the divisor,
        // so it also fits in WIDTH bits and can be kept unchanged.
        w_div_step = w_div_diff[WIDTH] ?
                     {w_rem_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0} :
                     {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

        w_prod = r_neg ? -r_acc : r_acc;
        w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_sa  ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

        if (r_dz) begin
            w_fin_hi = r_acc[2*WIDTH-1:WIDTH];
            w_fin_lo = r_acc[WIDTH-1:0];
        end else if (r_is_div) begin
            w_fin_hi = w_rem;
            w_fin_lo = w_quo;
        end else begin
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; divide-by-zero skips the iteration phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_iter) begin
                        w_state_nxt = S_DONE;
                    end else if (w_div_zero) begin
                        w_state_nxt = S_SIGN;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == (SHW+1)'(1)) begin
                    w_state_nxt = S_SIGN;
                end
            end
            S_SIGN:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit iteration and result/HI/LO writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_md     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_sa     <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div0 <= 1'b0;
                        if (!w_iter) begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            if (op == c_OP_MTHI) r_hi <= a;
                            if (op == c_OP_MTLO) r_lo <= a;
                        end else begin
                            r_is_div <= w_is_div;
                            r_neg    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_sa     <= w_signed && a[WIDTH-1];
                            r_dz     <= w_div_zero;
                            r_cnt    <= c_CNT_INIT;
                            r_md     <= w_b_mag;
                            // Divide-by-zero pre-loads the final {hi,lo} pattern
                            r_acc    <= w_div_zero ? {a, {WIDTH{1'b1}}}
                                                   : {{WIDTH{1'b0}}, w_a_mag};
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_SIGN: begin
                    r_hi     <= w_fin_hi;
                    r_lo     <= w_fin_lo;
                    r_result <= w_fin_lo;
                    r_zero   <= (w_fin_lo == '0);
                    r_div0   <= r_dz;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iter
//  Purpose  : Directed self-checking bench for alu_iter with a result
//             scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_iter;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,   SRA = 5'd4,  SLT = 5'd9;
    localparam logic [4:0] SLTU = 5'd10, LUI = 5'd11, MULT = 5'd16, MULTU = 5'd17;
    localparam logic [4:0] DIV = 5'd18, DIVU = 5'd19, MFHI = 5'd20, MFLO = 5'd21;
    localparam logic [4:0] MTHI = 5'd22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, div0;
    logic [31:0] result, hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        logic        chk_res;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    alu_iter #(.WIDTH(32), .SHW(5), .OPW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .hi     (hi),
        .lo     (lo),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one op, push its expectation, wait (bounded) for done and compare.
    task automatic run_op(input string tag, input logic [4:0] o,
                          input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] eres, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic ediv0,
                          input logic echk, input int elat, input int inject_at);
        exp_t e;
        exp_t got;
        int   edges;
        int   busy_cnt;
        e.tag = tag; e.res = eres; e.hi = ehi; e.lo = elo;
        e.div0 = ediv0; e.chk_res = echk; e.lat = elat;
        sbq.push_back(e);

        @(negedge clk);
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 5'(ADD);
        edges = 1;
        busy_cnt = 0;
        while (!done && edges < 200) begin
            if (busy) busy_cnt++;
            if (edges == inject_at) begin
                start = 1'b1; op = ADD; a = 32'd1; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;

        got = sbq.pop_front();
        chk({got.tag, ".done"},    32'(done), 32'd1);
        chk({got.tag, ".latency"}, 32'(edges), 32'(got.lat));
        chk({got.tag, ".busycyc"}, 32'(busy_cnt), 32'(got.lat - 1));
        chk({got.tag, ".busy"},    32'(busy), 32'd0);
        if (got.chk_res) begin
            chk({got.tag, ".result"}, result, got.res);
            chk({got.tag, ".zero"},   32'(zero), 32'(got.res == 32'd0));
        end
        chk({got.tag, ".hi"},   hi, got.hi);
        chk({got.tag, ".lo"},   lo, got.lo);
        chk({got.tag, ".div0"}, 32'(div0), 32'(got.div0));
        // leave the DONE cycle so the next start lands in IDLE
        @(posedge clk); #1;
    endtask

    task automatic single(input string tag, input logic [4:0] o,
                          input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] eres);
        run_op(tag, o, xa, xb, eres, m_hi, m_lo, 1'b0, 1'b1, 1, 0);
    endtask

    initial begin
        logic [63:0] p;
        int          sa, sbv;
        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",   32'(busy), 32'd0);
        chk("rst.done",   32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero",   32'(zero), 32'd1);
        chk("rst.hi",     hi, 32'd0);
        chk("rst.lo",     lo, 32'd0);
        chk("rst.div0",   32'(div0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single-cycle ops ----
        single("add",  ADD,  32'd7, 32'd5, 32'd12);
        single("sub",  SUB,  32'd5, 32'd5, 32'd0);
        single("sra",  SRA,  32'd4, 32'h8000_0000, 32'hF800_0000);
        single("slt",  SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
        single("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("lui",  LUI,  32'd0, 32'h0000_1234, 32'h1234_0000);

        // ---- multiply ----
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
        run_op("mult", MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, m_hi, m_lo, 1'b0, 1'b0, 34, 0);
        m_hi = 32'd1; m_lo = 32'hFFFF_FFFE;
        run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, m_hi, m_lo, 1'b0, 1'b0, 34, 0);

        // ---- divide ----
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, m_lo, m_hi, m_lo, 1'b0, 1'b1, 34, 0);
        m_hi = 32'd2; m_lo = 32'd14;
        run_op("divu", DIVU, 32'd100, 32'd7, m_lo, m_hi, m_lo, 1'b0, 1'b1, 34, 0);
        m_hi = 32'd9; m_lo = 32'hFFFF_FFFF;
        run_op("div0", DIV, 32'd9, 32'd0, m_lo, m_hi, m_lo, 1'b1, 1'b1, 2, 0);
        m_hi = 32'd0; m_lo = 32'h8000_0000;
        run_op("divmin", DIV, 32'h8000_0000, 32'hFFFF_FFFF, m_lo, m_hi, m_lo, 1'b0, 1'b1, 34, 0);

        // ---- HI/LO moves (div0 must be clear again) ----
        m_hi = 32'h0000_ABCD;
        single("mthi", MTHI, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD);
        single("mfhi", MFHI, 32'd0, 32'd0, 32'h0000_ABCD);

        // ---- start pulsed during a MULT is ignored ----
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFE2;
        run_op("mult_inj", MULT, 32'd6, 32'hFFFF_FFFB, 32'd0, m_hi, m_lo, 1'b0, 1'b0, 34, 10);
        single("mflo", MFLO, 32'd0, 32'd0, 32'hFFFF_FFE2);

        // ---- a few signed/unsigned products and quotients against a model ----
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            m_hi = p[63:32]; m_lo = p[31:0];
            run_op("rmult", MULT, ra, rb, 32'd0, m_hi, m_lo, 1'b0, 1'b0, 34, 0);
            p = {32'd0, ra} * {32'd0, rb};
            m_hi = p[63:32]; m_lo = p[31:0];
            run_op("rmultu", MULTU, ra, rb, 32'd0, m_hi, m_lo, 1'b0, 1'b0, 34, 0);
            sa  = $signed(ra);
            sbv = int'($urandom_range(1, 5000));
            if (i == 1) sbv = -sbv;
            m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv);
            run_op("rdiv", DIV, ra, 32'(sbv), m_lo, m_hi, m_lo, 1'b0, 1'b1, 34, 0);
        end

        // ---- reset in the middle of a DIV ----
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.hi",   hi, 32'd0);
        chk("midrst.lo",   lo, 32'd0);
        chk("midrst.zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        single("add_after_rst", ADD, 32'd3, 32'd4, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
